dcache_lsu: RTL
===============

Name: dcache_lsu

Overview:
- Load/store unit: the initiator side of the dcache port (r_en / w_en / addr / w_data / r_data).
- Accepts in-order load/store requests from the core pipeline over a valid/ready handshake and buffers them in a small request FIFO.
- Sequences each request onto the single-port dcache, absorbs the one-cycle registered read latency, and returns load data over a valid/ready response channel.
- Sits between the execute stage and dcache.

Parameters:
- DATA_W, 16, data word width; must match dcache word size.
- ADDR_W, 16, address width on both pipeline and dcache sides.
- MEM_WORDS, 256, number of dcache words; used only by the bounds check.
- FIFO_DEPTH, 2, request FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  FIFO not full.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  load data valid.
- resp_ready  in  1  pipeline accepts the response.
- resp_data  out  DATA_W  load result.
- resp_err  out  1  out-of-range flag; only with the optional feature, otherwise tied 0.
- dc_r_en  out  1  to dcache r_en.
- dc_w_en  out  1  to dcache w_en.
- dc_addr  out  ADDR_W  to dcache addr.
- dc_w_data  out  DATA_W  to dcache w_data.
- dc_r_data  in  DATA_W  from dcache r_data; valid the cycle after the read edge.

Behaviour:
- Reset (async, reset=1):
  - All outputs and registers clear: dc_r_en=0, dc_w_en=0, dc_addr=0, dc_w_data=0, resp_valid=0, resp_data=0, resp_err=0.
  - FIFO empty, so req_ready=1 once reset deasserts. FSM=IDLE.
  - Reset mid-operation drops all queued and in-flight requests; no response is produced for them.
- Handshake:
  - A request is accepted on a clk edge where req_valid && req_ready.
  - req_ready = !fifo_full, combinational from FIFO state only, never from req_valid.
  - Push and pop in the same cycle while full is not allowed: req_ready=0 when full, regardless of a pop.
- FSM states: IDLE, ISSUE, CAPTURE, RESP. All dc_* outputs are registered.
  - IDLE: if the FIFO is non-empty, pop the head into the request register and drive dc_addr, dc_w_data, and dc_r_en = !we, dc_w_en = we. Next state ISSUE.
  - ISSUE (one cycle, enables high): the dcache samples at the closing edge. Enables drop to 0. Store → IDLE; load → CAPTURE.
  - CAPTURE: latch dc_r_data into resp_data and set resp_valid=1. Next state RESP.
  - RESP: hold resp_valid and resp_data stable until resp_ready=1. On that edge, clear resp_valid → IDLE.
- Latency, empty FIFO, acceptance at edge T:
  - Enables high during cycle T+1..T+2.
  - Load resp_valid rises after edge T+3.
  - Store completes at edge T+2. Back-to-back stores therefore issue every 2 cycles.
- Ordering:
  - Strictly in order; no reordering or bypass.
  - A store followed by a load to the same address returns the stored data, because the store's write edge precedes the load's read edge.
- Enable rules: dc_r_en and dc_w_en are never both 1 and are never high for more than one cycle per request.
- Addresses: dc_addr passes req_addr unmodified; truncation to the dcache index is the dcache's concern.
- Backpressure: while in RESP, the FIFO keeps accepting until full. req_ready falls when FIFO_DEPTH entries are queued.

Optional Feature:
- Macro: DCACHE_LSU_BOUNDS_CHECK_EN.
- Defined:
  - A request with addr ≥ MEM_WORDS is not issued to dcache; enables stay 0.
  - An out-of-range load goes IDLE→RESP directly with resp_data=0, resp_err=1.
  - An out-of-range store is dropped silently and takes one cycle in IDLE.
  - resp_err is cleared with resp_valid.
- Undefined: no check; all addresses are issued and resp_err is constant 0.

Decomposition:
- Package dcache_lsu_pkg holds:
  - FSM state encoding (2-bit: IDLE=0, ISSUE=1, CAPTURE=2, RESP=3).
  - Request entry layout {we, addr, wdata} and its width constant.
- Sub-module lsu_req_fifo: synchronous FIFO of FIFO_DEPTH entries.
  - Ports: push, pop, full, empty, din, dout.
  - Pointers carry an extra wrap bit; asynchronous active-high reset.

Test Plan:
- After reset, load addr 0x0005 with resp_ready=1 → dc_r_en one cycle with dc_addr=0x0005; resp_valid rises 3 cycles after acceptance; resp_data=0x0005 (dcache resets word i to i).
- Store 0x00A0←0xBEEF, then load 0x00A0 back-to-back → dc_w_en pulse, then dc_r_en pulse; resp_data=0xBEEF; exactly one response.
- Hold resp_ready=0 and push 3 loads (0x10, 0x11, 0x12) → first in RESP, req_ready=0 after 2 queued; release resp_ready → responses 0x0010, 0x0011, 0x0012 in order, each stable while stalled.
- Assert reset while in ISSUE with 2 entries queued → all outputs 0 immediately; req_ready=1 after release; no response emitted.
- With DCACHE_LSU_BOUNDS_CHECK_EN: load 0x0100 → no dc_r_en; resp_valid with resp_data=0, resp_err=1. Without the macro: dc_r_en issued, resp_err=0.
- Checker on every cycle: dc_r_en && dc_w_en never 1; each enable high at most one consecutive cycle.

Source files
------------

// File: rtl/dcache_lsu_pkg.sv
// Shared definitions for the dcache load/store unit: FSM state encoding and
// the request-entry layout {we, addr, wdata} carried through the request FIFO.
package dcache_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } lsu_state_e;

   // Entry is packed MSB-first as {we, addr, wdata}.
   function automatic int req_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// Request FIFO for the dcache LSU. Pointers carry an extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module lsu_req_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_reg;
   logic [PTR_W:0]   rd_ptr_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
         end
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr_reg[PTR_W-1:0]] <= din;
      end
   end

   assign dout  = mem[rd_ptr_reg[PTR_W-1:0]];
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                  (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

endmodule

// File: rtl/dcache_lsu.sv
// Load/store unit driving a single-port dcache with one-cycle registered reads.
// Optional DCACHE_LSU_BOUNDS_CHECK_EN suppresses requests with addr >= MEM_WORDS.
module dcache_lsu
   import dcache_lsu_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int MEM_WORDS  = 256,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              dc_r_en,
   output logic              dc_w_en,
   output logic [ADDR_W-1:0] dc_addr,
   output logic [DATA_W-1:0] dc_w_data,
   input  logic [DATA_W-1:0] dc_r_data
);
   localparam int REQ_W = req_width(ADDR_W, DATA_W);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MEM_WORDS < 1) begin : g_bad_param
      $error("dcache_lsu: FIFO_DEPTH must be a power of two >= 2 and MEM_WORDS >= 1");
   end

   lsu_state_e        state_reg;
   lsu_state_e        state_next;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [REQ_W-1:0]  fifo_din;
   logic [REQ_W-1:0]  fifo_dout;

   logic              head_we;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_wdata;
   logic              head_oob;

   logic              req_we_reg,     req_we_next;
   logic              dc_r_en_reg,    dc_r_en_next;
   logic              dc_w_en_reg,    dc_w_en_next;
   logic [ADDR_W-1:0] dc_addr_reg,    dc_addr_next;
   logic [DATA_W-1:0] dc_w_data_reg,  dc_w_data_next;
   logic              resp_valid_reg, resp_valid_next;
   logic [DATA_W-1:0] resp_data_reg,  resp_data_next;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
   logic              resp_err_reg,   resp_err_next;
`endif

   // Ready depends on FIFO occupancy only, so a pop cannot free a slot the same cycle.
   assign req_ready = !fifo_full;
   assign fifo_push = req_valid && !fifo_full;
   assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
   assign fifo_din  = {req_we, req_addr, req_wdata};
   assign {head_we, head_addr, head_wdata} = fifo_dout;

`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
   assign head_oob = (32'(head_addr) >= MEM_WORDS);
`else
   assign head_oob = 1'b0;
`endif

   lsu_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (fifo_pop) begin
               if (!head_oob) begin
                  state_next = ST_ISSUE;
               end else if (!head_we) begin
                  state_next = ST_RESP;
               end
            end
         end
         ST_ISSUE:   state_next = req_we_reg ? ST_IDLE : ST_CAPTURE;
         ST_CAPTURE: state_next = ST_RESP;
         ST_RESP: begin
            if (resp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default:    state_next = ST_IDLE;
      endcase
   end

   // Enables default low so each request raises its enable for exactly one cycle.
   always_comb begin
      req_we_next     = req_we_reg;
      dc_r_en_next    = 1'b0;
      dc_w_en_next    = 1'b0;
      dc_addr_next    = dc_addr_reg;
      dc_w_data_next  = dc_w_data_reg;
      resp_valid_next = resp_valid_reg;
      resp_data_next  = resp_data_reg;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
      resp_err_next   = resp_err_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (fifo_pop) begin
               if (!head_oob) begin
                  req_we_next    = head_we;
                  dc_r_en_next   = !head_we;
                  dc_w_en_next   = head_we;
                  dc_addr_next   = head_addr;
                  dc_w_data_next = head_wdata;
               end else if (!head_we) begin
                  resp_valid_next = 1'b1;
                  resp_data_next  = '0;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
                  resp_err_next   = 1'b1;
`endif
               end
            end
         end
         ST_CAPTURE: begin
            resp_valid_next = 1'b1;
            resp_data_next  = dc_r_data;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
            resp_err_next   = 1'b0;
`endif
         end
         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_next = 1'b0;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
               resp_err_next   = 1'b0;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_we_reg     <= 1'b0;
         dc_r_en_reg    <= 1'b0;
         dc_w_en_reg    <= 1'b0;
         dc_addr_reg    <= '0;
         dc_w_data_reg  <= '0;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= '0;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
         resp_err_reg   <= 1'b0;
`endif
      end else begin
         req_we_reg     <= req_we_next;
         dc_r_en_reg    <= dc_r_en_next;
         dc_w_en_reg    <= dc_w_en_next;
         dc_addr_reg    <= dc_addr_next;
         dc_w_data_reg  <= dc_w_data_next;
         resp_valid_reg <= resp_valid_next;
         resp_data_reg  <= resp_data_next;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
         resp_err_reg   <= resp_err_next;
`endif
      end
   end

   assign dc_r_en    = dc_r_en_reg;
   assign dc_w_en    = dc_w_en_reg;
   assign dc_addr    = dc_addr_reg;
   assign dc_w_data  = dc_w_data_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_data  = resp_data_reg;
`ifdef DCACHE_LSU_BOUNDS_CHECK_EN
   assign resp_err   = resp_err_reg;
`else
   assign resp_err   = 1'b0;
`endif

endmodule
